// File: rtl/pe_dot_driver.sv
// pe_dot_driver
// Sequences one floating-point processing element through a K-term dot
// product. For each product it clears the PE, hands over one operand pair per
// load pulse, and waits for the PE's done pulse before requesting the next
// pair. The final accumulator value goes out on a valid/ready result port.
// A per-term watchdog turns a PE that never answers into a flagged result
// carrying the last good partial sum.
// The driver only moves operands and results; it does no arithmetic on them.

module pe_dot_driver #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    // Command side
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,

    // Operand stream from the scheduler
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,

    // PE load/done protocol (driver is the initiator)
    output logic              pe_rst_o,
    output logic              pe_load_o,
    output logic [DATA_W-1:0] pe_row_o,
    output logic [DATA_W-1:0] pe_col_o,
    input  logic              pe_done_i,
    input  logic [DATA_W-1:0] pe_result_i,

    // Result port
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_err_o
);

    // The watchdog counts 0 .. TIMEOUT-1 while waiting on one term, so the
    // wait expires after exactly TIMEOUT cycles in WAIT without a done pulse.
    localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t              state_q;

    // Dot-product bookkeeping
    logic [LEN_W-1:0]    k_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic [DATA_W-1:0]   acc_q;

    // Registered outputs
    logic                busy_q;
    logic                op_ready_q;
    logic                pe_rst_q;
    logic                pe_load_q;
    logic [DATA_W-1:0]   pe_row_q;
    logic [DATA_W-1:0]   pe_col_q;
    logic                res_valid_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_err_q;

    // Next-state helpers and event decode
    logic [LEN_W-1:0]    cnt_d;
    logic [WDOG_W-1:0]   wdog_d;
    logic                op_fire;
    logic                term_done;
    logic                last_term;
    logic                wdog_expired;
    logic                res_fire;

    // Decode the handshake and timing events that the state machine acts on.
    always_comb begin
        cnt_d        = cnt_q + LEN_W'(1'b1);
        wdog_d       = wdog_q + WDOG_W'(1'b1);
        op_fire      = 1'b0;
        term_done    = 1'b0;
        wdog_expired = 1'b0;
        res_fire     = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                op_fire = op_valid_i & op_ready_q;
            end
            ST_WAIT: begin
                // A done pulse in the expiry cycle still counts as a good term.
                term_done    = pe_done_i;
                wdog_expired = ~pe_done_i & (wdog_q == WDOG_LAST);
            end
            ST_OUT: begin
                res_fire = res_valid_q & res_ready_i;
            end
            default: begin
                op_fire      = 1'b0;
                term_done    = 1'b0;
                wdog_expired = 1'b0;
                res_fire     = 1'b0;
            end
        endcase
        last_term = (cnt_d == k_q);
    end

    // Main control state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= {LEN_W{1'b0}};
            cnt_q       <= {LEN_W{1'b0}};
            wdog_q      <= {WDOG_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            pe_rst_q    <= 1'b0;
            pe_load_q   <= 1'b0;
            pe_row_q    <= {DATA_W{1'b0}};
            pe_col_q    <= {DATA_W{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {DATA_W{1'b0}};
            res_err_q   <= 1'b0;
        end else begin
            // PE clear and load are single-cycle pulses unless re-armed below.
            pe_rst_q  <= 1'b0;
            pe_load_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q    <= 1'b1;
                        k_q       <= len_i;
                        cnt_q     <= {LEN_W{1'b0}};
                        acc_q     <= {DATA_W{1'b0}};
                        res_err_q <= 1'b0;
                        if (len_i == {LEN_W{1'b0}}) begin
                            // Empty product: answer zero without touching the PE.
                            res_data_q  <= {DATA_W{1'b0}};
                            res_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else begin
                            pe_rst_q <= 1'b1;
                            state_q  <= ST_CLEAR;
                        end
                    end
                end

                ST_CLEAR: begin
                    // The clear pulse is on the PE this cycle; ask for the first pair.
                    op_ready_q <= 1'b1;
                    state_q    <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    if (op_fire) begin
                        pe_row_q   <= op_a_i;
                        pe_col_q   <= op_b_i;
                        pe_load_q  <= 1'b1;
                        op_ready_q <= 1'b0;
                        wdog_q     <= {WDOG_W{1'b0}};
                        state_q    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (term_done) begin
                        acc_q <= pe_result_i;
                        cnt_q <= cnt_d;
                        if (last_term) begin
                            res_data_q  <= pe_result_i;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else begin
                            op_ready_q <= 1'b1;
                            state_q    <= ST_ISSUE;
                        end
                    end else if (wdog_expired) begin
                        // PE is hung: report the last sum it did deliver.
                        res_err_q   <= 1'b1;
                        res_data_q  <= acc_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end

                ST_OUT: begin
                    if (res_fire) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet idle.
                    busy_q      <= 1'b0;
                    op_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign op_ready_o  = op_ready_q;
    assign pe_rst_o    = pe_rst_q;
    assign pe_load_o   = pe_load_q;
    assign pe_row_o    = pe_row_q;
    assign pe_col_o    = pe_col_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_err_o   = res_err_q;

endmodule
